// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit sitting between EX/MEM and MEM/WB.
// Turns a load or store in MEM into one req/ack transaction on the data-memory
// port, stalls the front of the pipeline until it completes, and registers the
// load result for MEM/WB. Non-memory instructions pass with no added latency.
//
// Optional feature: define LSU_TIMEOUT_EN to abort a BUSY access after TIMEOUT
// cycles without ack. An aborted access returns 32'hDEADBEEF on loads and pulses
// BusErrM for one cycle. Without the macro BUSY waits forever and BusErrM is 0.
module mem_stage_lsu #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MemWriteM,
    input  logic          MemtoRegM,
    input  logic [AW-1:0] ALUOutM,
    input  logic [DW-1:0] WriteDataM,
    output logic          DmemReq,
    output logic          DmemWe,
    output logic [AW-1:0] DmemAddr,
    output logic [DW-1:0] DmemWdata,
    input  logic [DW-1:0] DmemRdata,
    input  logic          DmemAck,
    output logic [DW-1:0] ReadDataM,
    output logic          StallM,
    output logic          BusErrM
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic          dmemReq_q;
    logic          dmemWe_q;
    logic [AW-1:0] dmemAddr_q;
    logic [DW-1:0] dmemWdata_q;
    logic [DW-1:0] readData_q;
    logic          memAccess;

    // The low address bits are dropped on purpose (word-aligned bus); TIMEOUT is
    // only consumed by the timeout build. Folding them here keeps both builds tidy.
    logic unusedBits;
    assign unusedBits = ^{ALUOutM[1:0], (TIMEOUT != 0)};

    // A store wins when both control bits are set, so any set bit means an access.
    assign memAccess = MemWriteM | MemtoRegM;

    // The pipeline is frozen while an access is being launched or is in flight.
    // DONE releases it so the instruction leaves MEM on the same edge MEM/WB
    // captures ReadDataM.
    assign StallM = ((state_q == IDLE) && memAccess) || (state_q == BUSY);

    assign DmemReq   = dmemReq_q;
    assign DmemWe    = dmemWe_q;
    assign DmemAddr  = dmemAddr_q;
    assign DmemWdata = dmemWdata_q;
    assign ReadDataM = readData_q;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] timeoutCnt_q;
    logic          busErr_q;

    assign BusErrM = busErr_q;

    // Transaction FSM with a watchdog: launch from IDLE, wait for ack or expiry in
    // BUSY, then spend one DONE cycle so the same instruction is never reissued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dmemReq_q    <= 1'b0;
            dmemWe_q     <= 1'b0;
            dmemAddr_q   <= '0;
            dmemWdata_q  <= '0;
            readData_q   <= '0;
            timeoutCnt_q <= '0;
            busErr_q     <= 1'b0;
        end else begin
            busErr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (memAccess) begin
                        dmemReq_q    <= 1'b1;
                        dmemWe_q     <= MemWriteM;
                        dmemAddr_q   <= {ALUOutM[AW-1:2], 2'b00};
                        dmemWdata_q  <= WriteDataM;
                        timeoutCnt_q <= '0;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    if (DmemAck) begin
                        dmemReq_q <= 1'b0;
                        dmemWe_q  <= 1'b0;
                        if (!dmemWe_q) begin
                            readData_q <= DmemRdata;
                        end
                        state_q <= DONE;
                    end else if (timeoutCnt_q == CW'(TIMEOUT - 1)) begin
                        dmemReq_q    <= 1'b0;
                        dmemWe_q     <= 1'b0;
                        timeoutCnt_q <= CW'(TIMEOUT);
                        if (!dmemWe_q) begin
                            readData_q <= DW'(32'hDEADBEEF);
                        end
                        busErr_q <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        timeoutCnt_q <= timeoutCnt_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
`else
    assign BusErrM = 1'b0;

    // Transaction FSM: launch from IDLE, wait as long as needed for ack in BUSY,
    // then spend one DONE cycle so the same instruction is never reissued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dmemReq_q   <= 1'b0;
            dmemWe_q    <= 1'b0;
            dmemAddr_q  <= '0;
            dmemWdata_q <= '0;
            readData_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (memAccess) begin
                        dmemReq_q   <= 1'b1;
                        dmemWe_q    <= MemWriteM;
                        dmemAddr_q  <= {ALUOutM[AW-1:2], 2'b00};
                        dmemWdata_q <= WriteDataM;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (DmemAck) begin
                        dmemReq_q <= 1'b0;
                        dmemWe_q  <= 1'b0;
                        if (!dmemWe_q) begin
                            readData_q <= DmemRdata;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: self-checking bench for mem_stage_lsu. A table of directed
// instructions with hand-computed results, then random instructions checked
// against a transaction-level model, then reset-abort and (when LSU_TIMEOUT_EN
// is defined) bus-timeout sequences.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic        MemWriteM;
    logic        MemtoRegM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic        DmemReq;
    logic        DmemWe;
    logic [31:0] DmemAddr;
    logic [31:0] DmemWdata;
    logic [31:0] DmemRdata;
    logic        DmemAck;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        BusErrM;

    int checkCount;
    int passCount;

    logic [31:0] modelRead;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] expAddr;
        int          expStall;
        logic [31:0] expRead;
    } vec_t;

    vec_t vecs[10];

    mem_stage_lsu #(
        .DW(32),
        .AW(32),
        .TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .MemWriteM(MemWriteM),
        .MemtoRegM(MemtoRegM),
        .ALUOutM(ALUOutM),
        .WriteDataM(WriteDataM),
        .DmemReq(DmemReq),
        .DmemWe(DmemWe),
        .DmemAddr(DmemAddr),
        .DmemWdata(DmemWdata),
        .DmemRdata(DmemRdata),
        .DmemAck(DmemAck),
        .ReadDataM(ReadDataM),
        .StallM(StallM),
        .BusErrM(BusErrM)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the flow ever loses step with the DUT.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Runs one instruction through MEM with a memory that acks after 'delay'
    // BUSY cycles. Entered and left in the drive phase (#1 after a posedge).
    task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata, input int delay,
                                 input logic [31:0] expAddr, input int expStall,
                                 input logic [31:0] expRead, input string tag);
        int stallSeen;
        stallSeen  = 0;
        MemWriteM  = wr;
        MemtoRegM  = rd;
        ALUOutM    = addr;
        WriteDataM = wdata;
        DmemAck    = 1'($urandom_range(0, 1));
        DmemRdata  = $urandom;
        if (!(wr | rd)) begin
            @(negedge clk);
            checkOutput({tag, " alu stall"}, 32'(StallM), 32'd0);
            checkOutput({tag, " alu req"}, 32'(DmemReq), 32'd0);
            @(posedge clk);
            #1;
            checkOutput({tag, " alu readdata"}, ReadDataM, expRead);
            return;
        end
        @(negedge clk);
        stallSeen += int'(StallM);
        checkOutput({tag, " idle req"}, 32'(DmemReq), 32'd0);
        @(posedge clk);
        #1;
        for (int k = 1; k <= delay; k++) begin
            DmemAck   = (k == delay);
            DmemRdata = (k == delay) ? rdata : $urandom;
            @(negedge clk);
            stallSeen += int'(StallM);
            checkOutput({tag, " busy req"}, 32'(DmemReq), 32'd1);
            checkOutput({tag, " busy we"}, 32'(DmemWe), 32'(wr));
            checkOutput({tag, " busy addr"}, DmemAddr, expAddr);
            if (wr) begin
                checkOutput({tag, " busy wdata"}, DmemWdata, wdata);
            end
            @(posedge clk);
            #1;
        end
        DmemAck   = 1'($urandom_range(0, 1));
        DmemRdata = $urandom;
        @(negedge clk);
        stallSeen += int'(StallM);
        checkOutput({tag, " done stall"}, 32'(StallM), 32'd0);
        checkOutput({tag, " done req"}, 32'(DmemReq), 32'd0);
        checkOutput({tag, " done readdata"}, ReadDataM, expRead);
        checkOutput({tag, " done buserr"}, 32'(BusErrM), 32'd0);
        checkOutput({tag, " stall cycles"}, 32'(stallSeen), 32'(expStall));
        @(posedge clk);
        #1;
    endtask

    // Main sequence: reset, directed table, random traffic, reset abort, timeout.
    initial begin
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;

        checkCount = 0;
        passCount  = 0;
        rst        = 1'b1;
        MemWriteM  = 1'b0;
        MemtoRegM  = 1'b0;
        ALUOutM    = '0;
        WriteDataM = '0;
        DmemRdata  = '0;
        DmemAck    = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0055, 32'h1111_1111, 32'h0,         0, 32'h0,         0, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0123, 32'h2222_2222, 32'h0,         0, 32'h0,         0, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'hFFFF_0000, 32'h3333_3333, 32'h0,         0, 32'h0,         0, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0106, 32'h0,         32'hCAFE_F00D, 1, 32'h0000_0104, 2, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678, 32'h5555_AAAA, 4, 32'h0000_0040, 5, 32'hCAFE_F00D};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hA1A1_A1A1, 1, 32'h0000_0010, 2, 32'hA1A1_A1A1};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0014, 32'h0,         32'hB2B2_B2B2, 1, 32'h0000_0014, 2, 32'hB2B2_B2B2};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_002B, 32'h0BAD_F00D, 32'hFFFF_0000, 2, 32'h0000_0028, 3, 32'hB2B2_B2B2};
        vecs[8] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0,         32'h1357_9BDF, 3, 32'hFFFF_FFFC, 4, 32'h1357_9BDF};
        vecs[9] = '{1'b0, 1'b0, 32'h0000_0007, 32'h4444_4444, 32'h0,         0, 32'h0,         0, 32'h1357_9BDF};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset req", 32'(DmemReq), 32'd0);
        checkOutput("reset we", 32'(DmemWe), 32'd0);
        checkOutput("reset addr", DmemAddr, 32'd0);
        checkOutput("reset wdata", DmemWdata, 32'd0);
        checkOutput("reset readdata", ReadDataM, 32'd0);
        checkOutput("reset stall", 32'(StallM), 32'd0);
        checkOutput("reset buserr", 32'(BusErrM), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                          vecs[i].delay, vecs[i].expAddr, vecs[i].expStall, vecs[i].expRead,
                          $sformatf("vec%0d", i));
        end

        modelRead = 32'h1357_9BDF;
        for (int i = 0; i < 40; i++) begin
            wr    = 1'($urandom_range(0, 1));
            rd    = 1'($urandom_range(0, 1));
            addr  = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            delay = int'($urandom_range(1, 6));
            if (rd && !wr) begin
                modelRead = rdata;
            end
            applyStimulus(wr, rd, addr, wdata, rdata, delay, addr & 32'hFFFF_FFFC,
                          (wr | rd) ? delay + 1 : 0, modelRead, $sformatf("rnd%0d", i));
        end

        MemWriteM  = 1'b0;
        MemtoRegM  = 1'b1;
        ALUOutM    = 32'h0000_0080;
        DmemAck    = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        MemtoRegM = 1'b0;
        DmemAck   = 1'b1;
        DmemRdata = 32'h7777_7777;
        @(negedge clk);
        checkOutput("abort req", 32'(DmemReq), 32'd0);
        checkOutput("abort stall", 32'(StallM), 32'd0);
        checkOutput("abort readdata", ReadDataM, 32'd0);
        @(posedge clk);
        #1;
        DmemAck = 1'b0;
        @(negedge clk);
        checkOutput("late ack readdata", ReadDataM, 32'd0);
        checkOutput("late ack req", 32'(DmemReq), 32'd0);
        checkOutput("late ack stall", 32'(StallM), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 32'h0000_0300, 32'h0, 32'h600D_CAFE, 2, 32'h0000_0300, 3,
                      32'h600D_CAFE, "recover");

`ifdef LSU_TIMEOUT_EN
        MemWriteM = 1'b0;
        MemtoRegM = 1'b1;
        ALUOutM   = 32'h0000_0200;
        DmemAck   = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            checkOutput($sformatf("timeout busy%0d req", k), 32'(DmemReq), 32'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("timeout req", 32'(DmemReq), 32'd0);
        checkOutput("timeout stall", 32'(StallM), 32'd0);
        checkOutput("timeout buserr", 32'(BusErrM), 32'd1);
        checkOutput("timeout readdata", ReadDataM, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        MemtoRegM = 1'b0;
        @(negedge clk);
        checkOutput("timeout buserr clear", 32'(BusErrM), 32'd0);
        @(posedge clk);
        #1;
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
